accum_sched: RTL and testbench

Round-robin scheduler that time-shares one accumulator adder core between NREQ requesters. Each requester owns a private accumulator context held inside this block. The block arbitrates requests, issues (context, operand) to the shared core, waits for completion, writes the sum back and returns it to the owner. It sits between per-lane test logic (the generate-loop lanes) and a single protected arithmetic core.

---
 rtl/accum_sched_if.sv | 33 +++
 rtl/accum_sched.sv | 154 +++++++++++++++
 tb/tb_accum_sched.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_sched_if.sv
// accum_sched_if: requester handshake, response and shared-core bundle.
// slave = scheduler view, master = requesters + core view.
interface accum_sched_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       clr;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_data;
    logic [NREQ-1:0]       err;
    logic                  core_start;
    logic [WIDTH-1:0]      core_a;
    logic [WIDTH-1:0]      core_b;
    logic [WIDTH-1:0]      core_sum;
    logic                  core_done;

    modport slave (
        input  req_valid, req_data, clr,
        input  core_sum, core_done,
        output req_ready, resp_valid, resp_data, err,
        output core_start, core_a, core_b
    );

    modport master (
        output req_valid, req_data, clr,
        output core_sum, core_done,
        input  req_ready, resp_valid, resp_data, err,
        input  core_start, core_a, core_b
    );
endinterface

// File: rtl/accum_sched.sv
// accum_sched: round-robin scheduler sharing one accumulator adder core
// between NREQ requesters, each with a private context held here.
// Ports: clk, rst_n (async, active low), bus (accum_sched_if.slave):
//   req_valid/req_data/req_ready  per-requester operand handshake
//   clr                           per-context synchronous clear
//   resp_valid/resp_data/err      per-requester result / abort pulses
//   core_start/core_a/core_b      issue to the shared core
//   core_sum/core_done            core result
// Optional: define ACCUM_SCHED_TIMEOUT_EN to abort a WAIT after
// TIMEOUT cycles without core_done (err pulse, context kept).
module accum_sched #(
    parameter int NREQ    = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst_n,
    accum_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("accum_sched: unsupported parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_last;
    logic [WIDTH-1:0] r_acc [NREQ];
    logic [NREQ-1:0]  r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_core_start;
    logic [WIDTH-1:0] r_core_a;
    logic [WIDTH-1:0] r_core_b;

    logic             w_gnt_vld;
    logic [IW-1:0]    w_gnt_idx;
    logic [IW-1:0]    w_cand;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_operand;

`ifdef ACCUM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  r_err;
`endif

    // Scan from the highest distance down so the requester closest
    // after r_last is the one left standing.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_last;
        w_cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(r_last) + k) % NREQ);
            if (bus.req_valid[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_gnt_vld)
            w_ready[w_gnt_idx] = 1'b1;
    end

    assign w_operand = bus.req_data[int'(w_gnt_idx) * WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_last       <= IW'(NREQ - 1);
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_core_start <= 1'b0;
            r_core_a     <= '0;
            r_core_b     <= '0;
            for (int i = 0; i < NREQ; i++)
                r_acc[i] <= '0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= '0;
`endif
        end else begin
            r_core_start <= 1'b0;
            r_resp_valid <= '0;
`ifdef ACCUM_SCHED_TIMEOUT_EN
            r_err        <= '0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_idx        <= w_gnt_idx;
                        // core sees the context as it stands in ISSUE
                        r_core_a     <= bus.clr[w_gnt_idx] ? '0
                                      : r_acc[w_gnt_idx];
                        r_core_b     <= w_operand;
                        r_core_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_last  <= r_idx;
                    r_state <= S_WAIT;
`ifdef ACCUM_SCHED_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (bus.core_done) begin
                        r_acc[r_idx]        <= bus.core_sum;
                        r_resp_data         <= bus.core_sum;
                        r_resp_valid[r_idx] <= 1'b1;
                        r_state             <= S_IDLE;
                    end
`ifdef ACCUM_SCHED_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err[r_idx] <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
            // placed last so a clear beats a same-edge writeback
            for (int i = 0; i < NREQ; i++)
                if (bus.clr[i])
                    r_acc[i] <= '0;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.core_start = r_core_start;
    assign bus.core_a     = r_core_a;
    assign bus.core_b     = r_core_b;
`ifdef ACCUM_SCHED_TIMEOUT_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = '0;
`endif
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: randomized + directed bench for accum_sched.
// Core model is a registered 1-cycle modulo adder.
`timescale 1ns/1ps
module tb_accum_sched;
    localparam int NREQ    = 2;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    accum_sched #(
        .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    bit   core_en;
    logic force_done = 1'b0;
    always @(posedge clk) begin
        bus.core_done <= core_en ? bus.core_start : force_done;
        bus.core_sum  <= bus.core_a + bus.core_b;
    end

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] m_acc [NREQ];
    int m_last;
    int g_grants[$];
    logic [WIDTH-1:0] g_last_rd;

    function automatic logic [NREQ-1:0] oh(input int r);
        return NREQ'(1) << r;
    endfunction

    task automatic cycle(output logic [NREQ-1:0] hs,
                         output logic [NREQ-1:0] rv,
                         output logic [WIDTH-1:0] rd,
                         output logic [NREQ-1:0] er);
        #1;
        hs = bus.req_valid & bus.req_ready;
        @(negedge clk);
        rv = bus.resp_valid;
        rd = bus.resp_data;
        er = bus.err;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.clr = '0;
        core_en = 1'b1;
        force_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
        m_last = NREQ - 1;
    endtask

    // one request, returns response data and cycles from handshake
    task automatic do_req(input int r, input logic [WIDTH-1:0] d,
                          input bit clr_wb,
                          output logic [WIDTH-1:0] rd, output int lat);
        logic [NREQ-1:0] hs, rv, er;
        logic [WIDTH-1:0] x;
        bit got;
        lat = -1;
        rd = '0;
        got = 0;
        bus.req_valid = bus.req_valid | oh(r);
        bus.req_data[r*WIDTH +: WIDTH] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(hs, rv, x, er);
            if ((hs & oh(r)) != '0) got = 1;
        end
        bus.req_valid = bus.req_valid & ~oh(r);
        if (got) begin
            for (int i = 1; i <= 20 && lat < 0; i++) begin
                if (i == 2 && clr_wb) bus.clr = bus.clr | oh(r);
                cycle(hs, rv, x, er);
                bus.clr = '0;
                if ((rv & oh(r)) != '0) begin
                    lat = i;
                    rd = x;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.resp_valid !== '0) begin
            failures++;
            $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid);
        end
        checks++;
        if (bus.resp_data !== '0) begin
            failures++;
            $display("FAIL rst_resp_data got=%h exp=0", bus.resp_data);
        end
        checks++;
        if (bus.err !== '0) begin
            failures++;
            $display("FAIL rst_err got=%b exp=0", bus.err);
        end
        checks++;
        if (bus.core_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_core_start got=%b exp=0", bus.core_start);
        end
        checks++;
        if (bus.core_a !== '0 || bus.core_b !== '0) begin
            failures++;
            $display("FAIL rst_core_ab got=%h/%h exp=0/0",
                     bus.core_a, bus.core_b);
        end
        bus.req_valid = '1;
        #1;
        checks++;
        if (bus.req_ready !== oh(0)) begin
            failures++;
            $display("FAIL rst_first_grant got=%b exp=%b",
                     bus.req_ready, oh(0));
        end
        bus.req_valid = '0;
    endtask

    // mode 0: both always valid (0,100); 1: random; 2: req0 sends 5
    task automatic test_traffic(input int mode, input int target,
                                input int maxc);
        logic [NREQ-1:0] v, cl, exp_hs, exp_rv, hs, rv, er;
        logic [WIDTH-1:0] d [NREQ];
        logic [WIDTH-1:0] rd, m_sum;
        bit pend [NREQ];
        bit busy;
        int m_idx, m_due, nresp, cyc, sel, c;
        apply_reset();
        g_grants.delete();
        busy = 0; nresp = 0; cyc = 0;
        m_idx = 0; m_due = 0; m_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            d[i] = '0;
            pend[i] = 0;
        end
        while ((nresp < target || busy) && cyc < maxc) begin
            cl = '0;
            v = '0;
            for (int r = 0; r < NREQ; r++) begin
                if (nresp >= target) begin
                    pend[r] = 0;
                end else if (mode == 0) begin
                    pend[r] = 1;
                    d[r] = WIDTH'(r * 100);
                end else if (mode == 2) begin
                    pend[r] = (r == 0);
                    d[r] = 5;
                end else if (pend[r]) begin
                    if ($urandom_range(7) == 0) pend[r] = 0;
                end else if ($urandom_range(1) == 0) begin
                    pend[r] = 1;
                    if ($urandom_range(3) == 0)
                        d[r] = 32'hFFFF_FFF0 + $urandom_range(15);
                    else
                        d[r] = $urandom;
                end else if (!(busy && m_idx == r)
                             && $urandom_range(5) == 0) begin
                    cl = cl | oh(r);
                end
                if (pend[r]) v = v | oh(r);
                bus.req_data[r*WIDTH +: WIDTH] = d[r];
            end
            sel = -1;
            if (!busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (sel < 0 && (v & oh(c)) != '0) sel = c;
                end
            end
            exp_hs = (sel >= 0) ? oh(sel) : '0;
            bus.req_valid = v;
            bus.clr = cl;
            cycle(hs, rv, rd, er);
            cyc++;
            checks++;
            if (hs !== exp_hs) begin
                failures++;
                $display("FAIL grant m%0d cyc=%0d got=%b exp=%b",
                         mode, cyc, hs, exp_hs);
            end
            exp_rv = (busy && cyc == m_due) ? oh(m_idx) : '0;
            checks++;
            if (rv !== exp_rv || er !== '0) begin
                failures++;
                $display("FAIL resp_pulse m%0d cyc=%0d got=%b/%b exp=%b/0",
                         mode, cyc, rv, er, exp_rv);
            end
            if (exp_rv != '0) begin
                checks++;
                if (rd !== m_sum) begin
                    failures++;
                    $display("FAIL resp_data m%0d cyc=%0d got=%h exp=%h",
                             mode, cyc, rd, m_sum);
                end
                m_acc[m_idx] = m_sum;
                busy = 0;
                nresp++;
                g_last_rd = rd;
            end
            for (int r = 0; r < NREQ; r++)
                if ((cl & oh(r)) != '0) m_acc[r] = '0;
            if (sel >= 0) begin
                busy = 1;
                m_idx = sel;
                m_sum = m_acc[sel] + d[sel];
                m_due = cyc + 2;
                m_last = sel;
                g_grants.push_back(sel);
                if (mode == 1) pend[sel] = 0;
            end
        end
        bus.req_valid = '0;
        bus.clr = '0;
        checks++;
        if (nresp < target || busy) begin
            failures++;
            $display("FAIL traffic_budget m%0d got=%0d exp=%0d",
                     mode, nresp, target);
        end
    endtask

    task automatic test_single();
        test_traffic(2, 10, 100);
        checks++;
        if (g_grants.size() != 10 || g_last_rd !== 32'd50) begin
            failures++;
            $display("FAIL single got=%0d/%0d exp=10/50",
                     g_grants.size(), g_last_rd);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        test_traffic(0, 4, 100);
        ok = (g_grants.size() == 4);
        for (int i = 0; i < g_grants.size(); i++)
            if (g_grants[i] != i % 2) ok = 0;
        checks++;
        if (!ok || g_last_rd !== 32'd200) begin
            failures++;
            $display("FAIL fairness got=%p/%0d exp=0,1,0,1/200",
                     g_grants, g_last_rd);
        end
    endtask

    task automatic test_random();
        test_traffic(1, 60, 3000);
    endtask

    task automatic test_clear_collision();
        logic [WIDTH-1:0] rd;
        int lat;
        apply_reset();
        do_req(1, 30, 0, rd, lat);
        checks++;
        if (rd !== 32'd30 || lat != 2) begin
            failures++;
            $display("FAIL clr_preload got=%0d/%0d exp=30/2", rd, lat);
        end
        do_req(1, 7, 1, rd, lat);
        checks++;
        if (rd !== 32'd37 || lat != 2) begin
            failures++;
            $display("FAIL clr_collide got=%0d/%0d exp=37/2", rd, lat);
        end
        do_req(1, 1, 0, rd, lat);
        checks++;
        if (rd !== 32'd1) begin
            failures++;
            $display("FAIL clr_after got=%0d exp=1", rd);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] rd;
        int lat;
        apply_reset();
        do_req(0, 32'hFFFF_FFFF, 0, rd, lat);
        do_req(0, 32'd2, 0, rd, lat);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++;
            $display("FAIL wrap got=%h exp=00000001", rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [NREQ-1:0] hs, rv, er, seen;
        logic [WIDTH-1:0] rd;
        int lat;
        bit got;
        apply_reset();
        core_en = 1'b0;
        bus.req_valid = oh(0);
        bus.req_data[0 +: WIDTH] = 32'd9;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(hs, rv, rd, er);
            if (hs[0]) got = 1;
        end
        bus.req_valid = '0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL midop_accept got=0 exp=1");
        end
        repeat (3) cycle(hs, rv, rd, er);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.core_a !== '0 || bus.core_b !== '0
            || bus.resp_valid !== '0) begin
            failures++;
            $display("FAIL midop_async got=%h/%h/%b exp=0/0/0",
                     bus.core_a, bus.core_b, bus.resp_valid);
        end
        cycle(hs, rv, rd, er);
        rst_n = 1'b1;
        force_done = 1'b1;
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            cycle(hs, rv, rd, er);
            force_done = 1'b0;
            seen = seen | rv | er;
        end
        checks++;
        if (seen !== '0) begin
            failures++;
            $display("FAIL midop_late_done got=%b exp=0", seen);
        end
        core_en = 1'b1;
        bus.req_valid = '1;
        #1;
        checks++;
        if (bus.req_ready !== oh(0)) begin
            failures++;
            $display("FAIL midop_grant got=%b exp=%b",
                     bus.req_ready, oh(0));
        end
        bus.req_valid = '0;
        @(negedge clk);
        do_req(0, 32'd3, 0, rd, lat);
        checks++;
        if (rd !== 32'd3) begin
            failures++;
            $display("FAIL midop_ctx0 got=%0d exp=3", rd);
        end
        do_req(1, 32'd4, 0, rd, lat);
        checks++;
        if (rd !== 32'd4) begin
            failures++;
            $display("FAIL midop_ctx1 got=%0d exp=4", rd);
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] hs, rv, er, seen;
        logic [WIDTH-1:0] rd;
        int lat;
        bit got;
`ifdef ACCUM_SCHED_TIMEOUT_EN
        int erc;
        logic [NREQ-1:0] erv;
`endif
        apply_reset();
        do_req(1, 32'd10, 0, rd, lat);
        core_en = 1'b0;
        bus.req_valid = oh(1);
        bus.req_data[WIDTH +: WIDTH] = 32'd5;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(hs, rv, rd, er);
            if (hs[1]) got = 1;
        end
        bus.req_valid = '0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL to_accept got=0 exp=1");
        end
`ifdef ACCUM_SCHED_TIMEOUT_EN
        erc = -1;
        erv = '0;
        seen = '0;
        for (int i = 1; i <= TIMEOUT + 8; i++) begin
            cycle(hs, rv, rd, er);
            seen = seen | rv;
            if (er != '0 && erc < 0) begin
                erc = i;
                erv = er;
            end
        end
        checks++;
        if (erc != TIMEOUT + 1 || erv !== oh(1) || seen !== '0) begin
            failures++;
            $display("FAIL to_err got=%0d/%b/%b exp=%0d/%b/0",
                     erc, erv, seen, TIMEOUT + 1, oh(1));
        end
        core_en = 1'b1;
        do_req(1, 32'd1, 0, rd, lat);
        checks++;
        if (rd !== 32'd11) begin
            failures++;
            $display("FAIL to_after got=%0d exp=11", rd);
        end
`else
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            cycle(hs, rv, rd, er);
            seen = seen | rv | er;
        end
        checks++;
        if (seen !== '0) begin
            failures++;
            $display("FAIL to_hold got=%b exp=0", seen);
        end
        bus.req_valid = oh(0);
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("FAIL to_ready got=%b exp=0", bus.req_ready);
        end
        bus.req_valid = '0;
        @(negedge clk);
        force_done = 1'b1;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle(hs, rv, rd, er);
            force_done = 1'b0;
            if (rv != '0) got = 1;
        end
        checks++;
        if (!got || rv !== oh(1) || rd !== 32'd15) begin
            failures++;
            $display("FAIL to_release got=%b/%0d exp=%b/15",
                     rv, rd, oh(1));
        end
        core_en = 1'b1;
        do_req(1, 32'd1, 0, rd, lat);
        checks++;
        if (rd !== 32'd16) begin
            failures++;
            $display("FAIL to_after got=%0d exp=16", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_clear_collision();
        test_wrap();
        test_random();
        test_reset_midop();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
